// File: rtl/block_game_pkg.sv
// block_game_pkg: shared FSM state encoding and default timing/gameplay parameters
//   Used by block_game_ctrl and block_speed_ctrl.
package block_game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [31:0] DEF_INIT_PERIOD    = 32'd50_000_000;
    localparam logic [31:0] DEF_MIN_PERIOD     = 32'd5_000_000;
    localparam logic [31:0] DEF_STEP           = 32'd5_000_000;
    localparam int          DEF_HITS_PER_LEVEL = 8;
    localparam int          DEF_LIVES          = 3;

endpackage

// File: rtl/block_speed_ctrl.sv
// block_speed_ctrl: level counter and shift-period (gene_time) decrement with floor
//   clk, rst     : clock, synchronous active-high reset
//   load         : reinitialise for a new game
//   level_up     : advance one level this cycle
//   level        : current level, saturates at 15
//   gene_time    : shift period, steps down by STEP, never below MIN_PERIOD
module block_speed_ctrl
    import block_game_pkg::*;
#(
    parameter logic [31:0] INIT_PERIOD = DEF_INIT_PERIOD,
    parameter logic [31:0] MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter logic [31:0] STEP        = DEF_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        level_up,
    output logic [3:0]  level,
    output logic [31:0] gene_time
);

    logic [31:0] gene_nx;

    // Check gene_time > STEP first so the subtraction can never wrap.
    always_comb
        gene_nx = (gene_time > STEP && gene_time - STEP > MIN_PERIOD) ? gene_time - STEP : MIN_PERIOD;

    always_ff @(posedge clk)
        if (rst || load) begin
            level     <= 4'd0;
            gene_time <= INIT_PERIOD;
        end else if (level_up) begin
            level     <= (level == 4'd15) ? level : level + 4'd1;
            gene_time <= gene_nx;
        end

endmodule

// File: rtl/block_game_ctrl.sv
// block_game_ctrl: game FSM, hit/escape scoring, lives and speed control for a falling-block game
//   Inputs : clk, rst (sync, active-high), start, pause, key_valid, key_lane[1:0],
//            shift_en, bottom_valid, bottom_lane[1:0]
//   Outputs: gene_time[31:0], run_en, field_rst, clear_bottom, score[15:0],
//            level[3:0], lives[1:0], state[1:0], game_over (all registered)
//   Macro  : BLOCK_CTRL_MISS_PENALTY_EN -- a non-hit key in PLAY costs one life
module block_game_ctrl
    import block_game_pkg::*;
#(
    parameter logic [31:0] INIT_PERIOD    = DEF_INIT_PERIOD,
    parameter logic [31:0] MIN_PERIOD     = DEF_MIN_PERIOD,
    parameter logic [31:0] STEP           = DEF_STEP,
    parameter int          HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
    parameter int          LIVES          = DEF_LIVES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        key_valid,
    input  logic [1:0]  key_lane,
    input  logic        shift_en,
    input  logic        bottom_valid,
    input  logic [1:0]  bottom_lane,
    output logic [31:0] gene_time,
    output logic        run_en,
    output logic        field_rst,
    output logic        clear_bottom,
    output logic [15:0] score,
    output logic [3:0]  level,
    output logic [1:0]  lives,
    output logic [1:0]  state,
    output logic        game_over
);

    state_t      cur, state_nx;
    logic        run_en_d, field_rst_d, game_over_d;
    logic        load, play, hit, escape, miss, lose, level_up, cleared;
    logic [15:0] hit_cnt;

    assign state = cur;

    always_ff @(posedge clk)
        if (rst) begin
            cur       <= IDLE;
            run_en    <= 1'b0;
            field_rst <= 1'b1;
            game_over <= 1'b0;
        end else begin
            cur       <= state_nx;
            run_en    <= run_en_d;
            field_rst <= field_rst_d;
            game_over <= game_over_d;
        end

    // OVER is taken from the registered lives, i.e. the cycle after lives shows 0.
    always_comb
        state_nx = (cur == IDLE || cur == OVER) ? (start ? PLAY : cur) :
                   (cur == PLAY) ? (lives == 2'd0 ? OVER : pause ? PAUSE : PLAY) :
                   (pause ? PLAY : PAUSE);

    always_comb begin
        run_en_d    = state_nx == PLAY;
        game_over_d = state_nx == OVER;
        field_rst_d = state_nx == IDLE || (cur == OVER && state_nx == PLAY);
    end

    always_comb begin
        load     = start && (cur == IDLE || cur == OVER);
        play     = cur == PLAY;
        hit      = play && key_valid && bottom_valid && !cleared && key_lane == bottom_lane;
        escape   = play && shift_en && bottom_valid && !cleared && !hit;
`ifdef BLOCK_CTRL_MISS_PENALTY_EN
        miss     = play && key_valid && !hit;
`else
        miss     = 1'b0;
`endif
        lose     = (escape || miss) && lives != 2'd0;
        level_up = hit && hit_cnt == 16'(HITS_PER_LEVEL - 1);
    end

    always_ff @(posedge clk)
        if (rst || load) begin
            score        <= 16'd0;
            lives        <= 2'(LIVES);
            hit_cnt      <= 16'd0;
            cleared      <= 1'b0;
            clear_bottom <= 1'b0;
        end else begin
            score        <= (hit && score != 16'hFFFF) ? score + 16'd1 : score;
            lives        <= lose ? lives - 2'd1 : lives;
            hit_cnt      <= level_up ? 16'd0 : hit ? hit_cnt + 16'd1 : hit_cnt;
            // shift_en wins over a same-cycle hit, leaving cleared at 0
            cleared      <= play ? (shift_en ? 1'b0 : hit ? 1'b1 : cleared) : cleared;
            clear_bottom <= hit;
        end

    block_speed_ctrl #(
        .INIT_PERIOD(INIT_PERIOD),
        .MIN_PERIOD (MIN_PERIOD),
        .STEP       (STEP)
    ) u_speed (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .level_up (level_up),
        .level    (level),
        .gene_time(gene_time)
    );

endmodule

// File: tb/tb_block_game_ctrl.sv
// tb_block_game_ctrl: scoreboard-driven self-checking bench for block_game_ctrl
module tb_block_game_ctrl;

`ifdef BLOCK_CTRL_MISS_PENALTY_EN
    localparam int MISS = 1;
`else
    localparam int MISS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, pause = 1'b0, key_valid = 1'b0, shift_en = 1'b0, bottom_valid = 1'b0;
    logic [1:0]  key_lane = 2'd0, bottom_lane = 2'd0;
    logic [31:0] gene_time;
    logic        run_en, field_rst, clear_bottom, game_over;
    logic [15:0] score;
    logic [3:0]  level;
    logic [1:0]  lives, state;

    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] sc;
        logic [3:0]  lv;
        logic [1:0]  li;
        logic [31:0] gt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    block_game_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .key_valid(key_valid), .key_lane(key_lane), .shift_en(shift_en),
        .bottom_valid(bottom_valid), .bottom_lane(bottom_lane),
        .gene_time(gene_time), .run_en(run_en), .field_rst(field_rst),
        .clear_bottom(clear_bottom), .score(score), .level(level),
        .lives(lives), .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(int st, int sc, int lv, int li, int gt);
        mk.st = 2'(st);
        mk.sc = 16'(sc);
        mk.lv = 4'(lv);
        mk.li = 2'(li);
        mk.gt = 32'(gt);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        start = 1'b0; pause = 1'b0; key_valid = 1'b0; shift_en = 1'b0;
    endtask

    task automatic new_game();
        rst = 1'b1; bottom_valid = 1'b0;
        cyc();
        rst = 1'b0; start = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        sb.push_back(mk(0, 0, 0, 3, 50_000_000));
        rst = 1'b1; start = 1'b1; key_valid = 1'b1; shift_en = 1'b1;
        cyc();
        rst = 1'b0;
        e = sb.pop_front();
        checks++; if (state !== e.st) begin failures++; $display("FAIL reset_state: got %0d want %0d", state, e.st); end
        checks++; if (gene_time !== e.gt) begin failures++; $display("FAIL reset_gene: got %0d want %0d", gene_time, e.gt); end
        checks++; if (lives !== e.li) begin failures++; $display("FAIL reset_lives: got %0d want %0d", lives, e.li); end
        checks++; if (score !== e.sc || level !== e.lv) begin failures++; $display("FAIL reset_score_level: got %0d/%0d want %0d/%0d", score, level, e.sc, e.lv); end
        checks++; if ({run_en, field_rst, clear_bottom, game_over} !== 4'b0100) begin failures++; $display("FAIL reset_flags: got %b want 0100", {run_en, field_rst, clear_bottom, game_over}); end
        sb.push_back(mk(0, 0, 0, 3, 50_000_000));
        pause = 1'b1; key_valid = 1'b1; shift_en = 1'b1; bottom_valid = 1'b1;
        cyc();
        e = sb.pop_front();
        checks++; if (state !== e.st || field_rst !== 1'b1) begin failures++; $display("FAIL idle_ignore: got state %0d field_rst %b want %0d 1", state, field_rst, e.st); end
        checks++; if (lives !== e.li || score !== e.sc) begin failures++; $display("FAIL idle_hold: got lives %0d score %0d want %0d %0d", lives, score, e.li, e.sc); end
        bottom_valid = 1'b0;
    endtask

    task automatic test_start();
        sb.push_back(mk(1, 0, 0, 3, 50_000_000));
        start = 1'b1;
        cyc();
        e = sb.pop_front();
        checks++; if (state !== e.st) begin failures++; $display("FAIL start_state: got %0d want %0d", state, e.st); end
        checks++; if (gene_time !== e.gt || lives !== e.li) begin failures++; $display("FAIL start_load: got %0d/%0d want %0d/%0d", gene_time, lives, e.gt, e.li); end
        checks++; if (field_rst !== 1'b0 || run_en !== 1'b1 || game_over !== 1'b0) begin failures++; $display("FAIL start_flags: got fr=%b run=%b go=%b want 0 1 0", field_rst, run_en, game_over); end
        sb.push_back(mk(1, 0, 0, 3, 50_000_000));
        start = 1'b1;
        cyc();
        e = sb.pop_front();
        checks++; if (state !== e.st || run_en !== 1'b1) begin failures++; $display("FAIL start_in_play: got %0d want %0d", state, e.st); end
    endtask

    task automatic test_hit();
        new_game();
        bottom_valid = 1'b1; bottom_lane = 2'd2;
        sb.push_back(mk(1, 1, 0, 3, 50_000_000));
        key_valid = 1'b1; key_lane = 2'd2;
        cyc();
        e = sb.pop_front();
        checks++; if (score !== e.sc) begin failures++; $display("FAIL hit_score: got %0d want %0d", score, e.sc); end
        checks++; if (clear_bottom !== 1'b1) begin failures++; $display("FAIL hit_clear_pulse: got %b want 1", clear_bottom); end
        sb.push_back(mk(1, 1, 0, 3 - MISS, 50_000_000));
        key_valid = 1'b1; key_lane = 2'd2;
        cyc();
        e = sb.pop_front();
        checks++; if (clear_bottom !== 1'b0) begin failures++; $display("FAIL hit_clear_one_cycle: got %b want 0", clear_bottom); end
        checks++; if (score !== e.sc || lives !== e.li) begin failures++; $display("FAIL hit_repeat: got score %0d lives %0d want %0d %0d", score, lives, e.sc, e.li); end
        sb.push_back(mk(1, 1, 0, 3 - MISS, 50_000_000));
        shift_en = 1'b1;
        cyc();
        e = sb.pop_front();
        checks++; if (lives !== e.li || clear_bottom !== 1'b0) begin failures++; $display("FAIL hit_cleared_shift: got lives %0d cb %b want %0d 0", lives, clear_bottom, e.li); end
        sb.push_back(mk(1, 2, 0, 3 - MISS, 50_000_000));
        key_valid = 1'b1; key_lane = 2'd2;
        cyc();
        e = sb.pop_front();
        checks++; if (score !== e.sc || clear_bottom !== 1'b1) begin failures++; $display("FAIL hit_after_shift: got score %0d cb %b want %0d 1", score, clear_bottom, e.sc); end
    endtask

    task automatic test_escape();
        new_game();
        bottom_valid = 1'b1; bottom_lane = 2'd1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(1, 0, 0, 2 - i, 50_000_000));
            shift_en = 1'b1;
            cyc();
            e = sb.pop_front();
            checks++; if (lives !== e.li || state !== e.st) begin failures++; $display("FAIL escape_%0d: got lives %0d state %0d want %0d %0d", i, lives, state, e.li, e.st); end
        end
        sb.push_back(mk(3, 0, 0, 0, 50_000_000));
        cyc();
        e = sb.pop_front();
        checks++; if (state !== e.st || game_over !== 1'b1 || run_en !== 1'b0) begin failures++; $display("FAIL over_entry: got state %0d go %b run %b want %0d 1 0", state, game_over, run_en, e.st); end
        sb.push_back(mk(3, 0, 0, 0, 50_000_000));
        shift_en = 1'b1; pause = 1'b1; key_valid = 1'b1; key_lane = 2'd1;
        cyc();
        e = sb.pop_front();
        checks++; if (state !== e.st || lives !== e.li || score !== e.sc) begin failures++; $display("FAIL over_ignore: got state %0d lives %0d score %0d want %0d %0d %0d", state, lives, score, e.st, e.li, e.sc); end
        bottom_valid = 1'b0;
        sb.push_back(mk(1, 0, 0, 3, 50_000_000));
        start = 1'b1;
        cyc();
        e = sb.pop_front();
        checks++; if (state !== e.st || score !== e.sc || lives !== e.li) begin failures++; $display("FAIL restart: got state %0d score %0d lives %0d want %0d %0d %0d", state, score, lives, e.st, e.sc, e.li); end
        checks++; if (field_rst !== 1'b1 || game_over !== 1'b0) begin failures++; $display("FAIL restart_field_rst: got fr %b go %b want 1 0", field_rst, game_over); end
        cyc();
        checks++; if (field_rst !== 1'b0) begin failures++; $display("FAIL restart_field_rst_pulse: got %b want 0", field_rst); end
    endtask

    task automatic test_hit_shift();
        new_game();
        bottom_valid = 1'b1; bottom_lane = 2'd3;
        sb.push_back(mk(1, 1, 0, 3, 50_000_000));
        key_valid = 1'b1; key_lane = 2'd3; shift_en = 1'b1;
        cyc();
        e = sb.pop_front();
        checks++; if (lives !== e.li || score !== e.sc) begin failures++; $display("FAIL hit_shift: got lives %0d score %0d want %0d %0d", lives, score, e.li, e.sc); end
        sb.push_back(mk(1, 1, 0, 2, 50_000_000));
        shift_en = 1'b1;
        cyc();
        e = sb.pop_front();
        checks++; if (lives !== e.li) begin failures++; $display("FAIL hit_shift_cleared0: got lives %0d want %0d", lives, e.li); end
    endtask

    task automatic test_levels();
        new_game();
        bottom_valid = 1'b1; bottom_lane = 2'd0;
        for (int k = 1; k <= 88; k++) begin
            int lvl, g;
            lvl = k / 8;
            g = 50_000_000 - lvl * 5_000_000;
            if (g < 5_000_000) g = 5_000_000;
            sb.push_back(mk(1, k, lvl, 3, g));
            key_valid = 1'b1; key_lane = 2'd0; shift_en = 1'b1;
            cyc();
            e = sb.pop_front();
            checks++; if (level !== e.lv || gene_time !== e.gt) begin failures++; $display("FAIL level_hit%0d: got level %0d gene %0d want %0d %0d", k, level, gene_time, e.lv, e.gt); end
            checks++; if (score !== e.sc || lives !== e.li) begin failures++; $display("FAIL level_score%0d: got score %0d lives %0d want %0d %0d", k, score, lives, e.sc, e.li); end
        end
    endtask

    task automatic test_pause();
        new_game();
        sb.push_back(mk(2, 0, 0, 3, 50_000_000));
        pause = 1'b1;
        cyc();
        e = sb.pop_front();
        checks++; if (state !== e.st || run_en !== 1'b0) begin failures++; $display("FAIL pause_enter: got state %0d run %b want %0d 0", state, run_en, e.st); end
        bottom_valid = 1'b1; bottom_lane = 2'd1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(2, 0, 0, 3, 50_000_000));
            if (i == 0) begin key_valid = 1'b1; key_lane = 2'd1; end
            if (i == 1) shift_en = 1'b1;
            if (i == 2) begin key_valid = 1'b1; key_lane = 2'd3; end
            if (i == 3) start = 1'b1;
            cyc();
            e = sb.pop_front();
            checks++; if (state !== e.st || score !== e.sc || lives !== e.li || run_en !== 1'b0) begin failures++; $display("FAIL pause_hold%0d: got state %0d score %0d lives %0d run %b want %0d %0d %0d 0", i, state, score, lives, run_en, e.st, e.sc, e.li); end
        end
        sb.push_back(mk(1, 0, 0, 3, 50_000_000));
        pause = 1'b1;
        cyc();
        e = sb.pop_front();
        checks++; if (state !== e.st || run_en !== 1'b1) begin failures++; $display("FAIL pause_resume: got state %0d run %b want %0d 1", state, run_en, e.st); end
        sb.push_back(mk(1, 0, 0, 2, 50_000_000));
        shift_en = 1'b1;
        cyc();
        e = sb.pop_front();
        checks++; if (lives !== e.li) begin failures++; $display("FAIL pause_no_clear: got lives %0d want %0d", lives, e.li); end
    endtask

    task automatic test_miss();
        new_game();
        bottom_valid = 1'b1; bottom_lane = 2'd1;
        sb.push_back(mk(1, 0, 0, 3 - MISS, 50_000_000));
        key_valid = 1'b1; key_lane = 2'd2;
        cyc();
        e = sb.pop_front();
        checks++; if (lives !== e.li || score !== e.sc) begin failures++; $display("FAIL miss_key: got lives %0d score %0d want %0d %0d", lives, score, e.li, e.sc); end
        sb.push_back(mk(1, 0, 0, 2 - MISS, 50_000_000));
        key_valid = 1'b1; key_lane = 2'd2; shift_en = 1'b1;
        cyc();
        e = sb.pop_front();
        checks++; if (lives !== e.li) begin failures++; $display("FAIL miss_escape_once: got lives %0d want %0d", lives, e.li); end
    endtask

    task automatic test_rst_mid();
        new_game();
        bottom_valid = 1'b1; bottom_lane = 2'd0;
        sb.push_back(mk(1, 1, 0, 3, 50_000_000));
        key_valid = 1'b1; key_lane = 2'd0;
        cyc();
        e = sb.pop_front();
        checks++; if (score !== e.sc) begin failures++; $display("FAIL rst_mid_pre: got score %0d want %0d", score, e.sc); end
        sb.push_back(mk(0, 0, 0, 3, 50_000_000));
        rst = 1'b1; start = 1'b1; pause = 1'b1; key_valid = 1'b1; shift_en = 1'b1;
        cyc();
        rst = 1'b0;
        e = sb.pop_front();
        checks++; if (state !== e.st || score !== e.sc || lives !== e.li) begin failures++; $display("FAIL rst_mid: got state %0d score %0d lives %0d want %0d %0d %0d", state, score, lives, e.st, e.sc, e.li); end
        checks++; if ({run_en, field_rst, clear_bottom, game_over} !== 4'b0100) begin failures++; $display("FAIL rst_mid_flags: got %b want 0100", {run_en, field_rst, clear_bottom, game_over}); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_escape();
        test_hit_shift();
        test_levels();
        test_pause();
        test_miss();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_game_ctrl.md
BLOCK_GAME_CTRL -- requirements
Module: block_game_ctrl

Interface
REQ-001 SHALL have parameter INIT_PERIOD, default 32'd50_000_000: gene_time value at game start, in clk cycles.
REQ-002 SHALL have parameter MIN_PERIOD, default 32'd5_000_000: gene_time floor.
REQ-003 SHALL have parameter STEP, default 32'd5_000_000: gene_time decrement per level.
REQ-004 SHALL have parameter HITS_PER_LEVEL, default 8: hits needed to advance one level.
REQ-005 SHALL have parameter LIVES, default 3: lives at game start, range 1..3.
REQ-006 SHALL use one clock; reset is synchronous and active-high. Ports, in order:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: start or restart a game
- pause  in  1  one-cycle pulse: toggle PLAY/PAUSE
- key_valid  in  1  one-cycle pulse: player pressed a lane key
- key_lane  in  2  lane of the pressed key
- shift_en  in  1  generator shift pulse (one cycle per playfield shift)
- bottom_valid  in  1  bottom row holds a block
- bottom_lane  in  2  lane of the bottom block
- gene_time  out  32  shift period sent to the generator
- run_en  out  1  high only in PLAY; datapath advances only when high
- field_rst  out  1  clears the playfield
- clear_bottom  out  1  one-cycle pulse: erase the bottom block
- score  out  16  hit count
- level  out  4  current level
- lives  out  2  remaining lives
- state  out  2  IDLE=0, PLAY=1, PAUSE=2, OVER=3
- game_over  out  1  high in OVER

Function
REQ-007 SHALL implement FSM IDLE->PLAY on start; PLAY<->PAUSE on pause; PLAY->OVER when lives reach 0; OVER->PLAY on start.
REQ-008 SHALL, on any entry to PLAY from IDLE or OVER, load score=0, level=0, lives=LIVES, gene_time=INIT_PERIOD, hit counter=0 and cleared flag=0.
REQ-009 SHALL assert field_rst continuously in IDLE and for exactly one cycle on the OVER->PLAY transition.
REQ-010 SHALL, in PLAY, count a hit when key_valid=1, bottom_valid=1, cleared=0 and key_lane==bottom_lane.
REQ-011 SHALL, on a hit: increment score, saturating at 16'hFFFF; pulse clear_bottom on the next cycle; set cleared.
REQ-012 SHALL clear the cleared flag on every shift_en in PLAY.
REQ-013 SHALL count an escape when shift_en=1, bottom_valid=1 and cleared=0; an escape decrements lives.
REQ-014 SHALL give the hit priority when a hit and shift_en occur in the same cycle: no life is lost and cleared is left at 0.
REQ-015 SHALL decrement lives at most once per cycle, and SHALL never decrement below 0.
REQ-016 SHALL, on the HITS_PER_LEVEL-th hit of a level: reset the hit counter, increment level (saturating at 15), and set gene_time = max(gene_time-STEP, MIN_PERIOD) without underflow.
REQ-017 SHALL register all outputs: every effect of an event at cycle N is visible at cycle N+1.
REQ-018 SHALL enter OVER in the cycle after lives becomes 0; game_over=1 and run_en=0 in OVER.
REQ-019 SHALL ignore key_valid and shift_en in IDLE, PAUSE and OVER; score, level, lives and gene_time hold.
REQ-020 SHALL ignore pause in IDLE and OVER, and SHALL ignore start in PLAY and PAUSE.

Reset
REQ-021 SHALL, on rst=1, set: state=IDLE, gene_time=INIT_PERIOD, score=0, level=0, lives=LIVES, run_en=0, field_rst=1, clear_bottom=0, game_over=0, cleared=0, hit counter=0.
REQ-022 SHALL let rst asserted mid-game override all other inputs in that cycle.

Configuration
REQ-023 SHALL support macro BLOCK_CTRL_MISS_PENALTY_EN:
- Defined: in PLAY, a key_valid that is not a hit costs one life. A miss and an escape in the same cycle cost one life total.
- Undefined: non-hit keys are ignored; only escapes cost lives.

Structure
REQ-024 SHALL place the state encoding constants and the default parameter values in shared package block_game_pkg.
REQ-025 SHALL implement the level counter and gene_time decrement/floor logic in sub-module block_speed_ctrl.

Verification
REQ-026 SHALL cover: rst, then start -> state=1, gene_time=50_000_000, lives=3, field_rst=1 in IDLE then 0.
REQ-027 SHALL cover: bottom_lane=2, bottom_valid=1, key_lane=2 pulse -> score=1 next cycle, clear_bottom one-cycle pulse; second key before shift_en -> no score change.
REQ-028 SHALL cover: 3 shift_en with an uncleared bottom block -> lives 3->2->1->0, then state=3, game_over=1; start -> PLAY with score=0.
REQ-029 SHALL cover: hit and shift_en in the same cycle -> lives unchanged, score+1.
REQ-030 SHALL cover: 80 hits with STEP=5_000_000 -> level=10, gene_time floored at 5_000_000; level 11 -> gene_time still 5_000_000.
REQ-031 SHALL cover: pause pulse, then key_valid/shift_en -> no changes, run_en=0; with BLOCK_CTRL_MISS_PENALTY_EN defined, wrong key in PLAY -> lives-1; without the macro -> lives unchanged.
